// File: rtl/cook_timer.sv
// Microwave cook timer: keypad-loaded MM:SS BCD countdown, one decrement per
// second while the magnetron is on, with zero level and done pulse outputs.
module cook_timer #(
    parameter int unsigned TICK_DIV = 100
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       enable,
    input  logic       clearn,
    input  logic       digit_valid,
    input  logic [3:0] digit,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       timer_done,
    output logic       done_pulse
);

    localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned DW = 4;
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] r_presc;
    logic [DW-1:0] r_mt;
    logic [DW-1:0] r_mo;
    logic [DW-1:0] r_st;
    logic [DW-1:0] r_so;
    logic          r_done_pulse;

    logic          w_zero;
    logic          w_run;
    logic          w_tick;
    logic          w_digit_ok;
    logic [PW-1:0] w_presc_nxt;
    logic [DW-1:0] w_mt_dec;
    logic [DW-1:0] w_mo_dec;
    logic [DW-1:0] w_st_dec;
    logic [DW-1:0] w_so_dec;
    logic          w_dec_zero;
    logic [DW-1:0] w_mt_nxt;
    logic [DW-1:0] w_mo_nxt;
    logic [DW-1:0] w_st_nxt;
    logic [DW-1:0] w_so_nxt;
    logic          w_done_pulse_nxt;

    assign w_zero     = (r_mt == '0) && (r_mo == '0) && (r_st == '0) && (r_so == '0);
    assign w_run      = enable && !w_zero;
    assign w_tick     = w_run && (r_presc == TICK_LAST);
    assign w_digit_ok = digit_valid && (digit <= 4'd9);

    // Prescaler held at 0 unless actively counting, so every resume waits a full second.
    always_comb begin
        w_presc_nxt = '0;
        if (w_run && !w_tick) begin
            w_presc_nxt = r_presc + PW'(1);
        end
    end

    // Mixed-radix borrow; seconds-tens above 5 are decremented digit-wise, never normalized.
    always_comb begin
        w_mt_dec = r_mt;
        w_mo_dec = r_mo;
        w_st_dec = r_st;
        w_so_dec = r_so;
        if (r_so != '0) begin
            w_so_dec = r_so - DW'(1);
        end else begin
            w_so_dec = DW'(9);
            if (r_st != '0) begin
                w_st_dec = r_st - DW'(1);
            end else begin
                w_st_dec = DW'(5);
                if (r_mo != '0) begin
                    w_mo_dec = r_mo - DW'(1);
                end else begin
                    w_mo_dec = DW'(9);
                    w_mt_dec = r_mt - DW'(1);
                end
            end
        end
    end

    assign w_dec_zero = (w_mt_dec == '0) && (w_mo_dec == '0) &&
                        (w_st_dec == '0) && (w_so_dec == '0);

    // Keypad and clear only act while the oven is off; a running timer only decrements.
    always_comb begin
        w_mt_nxt = r_mt;
        w_mo_nxt = r_mo;
        w_st_nxt = r_st;
        w_so_nxt = r_so;
        if (enable) begin
            if (w_tick) begin
                w_mt_nxt = w_mt_dec;
                w_mo_nxt = w_mo_dec;
                w_st_nxt = w_st_dec;
                w_so_nxt = w_so_dec;
            end
        end else if (!clearn) begin
            w_mt_nxt = '0;
            w_mo_nxt = '0;
            w_st_nxt = '0;
            w_so_nxt = '0;
        end else if (w_digit_ok) begin
            w_mt_nxt = r_mo;
            w_mo_nxt = r_st;
            w_st_nxt = r_so;
            w_so_nxt = digit;
        end
    end

    assign w_done_pulse_nxt = w_tick && w_dec_zero;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_presc      <= '0;
            r_mt         <= '0;
            r_mo         <= '0;
            r_st         <= '0;
            r_so         <= '0;
            r_done_pulse <= 1'b0;
        end else begin
            r_presc      <= w_presc_nxt;
            r_mt         <= w_mt_nxt;
            r_mo         <= w_mo_nxt;
            r_st         <= w_st_nxt;
            r_so         <= w_so_nxt;
            r_done_pulse <= w_done_pulse_nxt;
        end
    end

    assign min_tens   = r_mt;
    assign min_ones   = r_mo;
    assign sec_tens   = r_st;
    assign sec_ones   = r_so;
    assign timer_done = w_zero;
    assign done_pulse = r_done_pulse;

endmodule

// File: tb/tb_cook_timer.sv
// Directed bench for cook_timer with TICK_DIV=4: vector table plus hand-written
// sequences for tick timing, pause/resume, zero handling and async reset.
module tb_cook_timer;

    logic       clk;
    logic       resetn;
    logic       enable;
    logic       clearn;
    logic       digit_valid;
    logic [3:0] digit;
    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic       timer_done;
    logic       done_pulse;

    int n_cmp  = 0;
    int n_fail = 0;

    cook_timer #(.TICK_DIV(4)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .enable     (enable),
        .clearn     (clearn),
        .digit_valid(digit_valid),
        .digit      (digit),
        .min_tens   (min_tens),
        .min_ones   (min_ones),
        .sec_tens   (sec_tens),
        .sec_ones   (sec_ones),
        .timer_done (timer_done),
        .done_pulse (done_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic        cl;
        logic        dv;
        logic [3:0]  dg;
        logic [15:0] exp_disp;
        logic        exp_done;
        logic        exp_pulse;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [15:0] exp_disp,
                         input logic exp_done, input logic exp_pulse);
        logic [17:0] act;
        logic [17:0] req;
        act = {min_tens, min_ones, sec_tens, sec_ones, timer_done, done_pulse};
        req = {exp_disp, exp_done, exp_pulse};
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got disp=%h done=%b pulse=%b, want disp=%h done=%b pulse=%b",
                     name, act[17:2], act[1], act[0], req[17:2], req[1], req[0]);
        end
    endtask

    // One clock: inputs change at the falling edge, outputs sampled 1 ns after the rising edge.
    task automatic cyc(input logic en, input logic cl, input logic dv, input logic [3:0] dg);
        @(negedge clk);
        enable      = en;
        clearn      = cl;
        digit_valid = dv;
        digit       = dg;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b1, 1'b0, 4'd0);
    endtask

    initial begin
        vecs[0] = '{1'b0, 1'b1, 1'b1, 4'd1,  16'h0001, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 1'b1, 4'd3,  16'h0013, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 1'b1, 4'd0,  16'h0130, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 4'd12, 16'h0130, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 1'b1, 1'b0, 4'd0,  16'h0130, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 4'd0,  16'h0130, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 1'b1, 1'b0, 4'd0,  16'h0130, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 1'b1, 1'b0, 4'd0,  16'h0129, 1'b0, 1'b0};

        resetn      = 1'b0;
        enable      = 1'b0;
        clearn      = 1'b1;
        digit_valid = 1'b0;
        digit       = 4'd0;
        #12;
        check("reset", 16'h0000, 1'b1, 1'b0);
        @(negedge clk);
        resetn = 1'b1;

        for (int i = 0; i < 8; i++) begin
            cyc(vecs[i].en, vecs[i].cl, vecs[i].dv, vecs[i].dg);
            check($sformatf("vec%0d", i), vecs[i].exp_disp, vecs[i].exp_done, vecs[i].exp_pulse);
        end

        // 01:29 down to 01:00, then borrow across the minute
        run(115);
        check("pre_0100", 16'h0101, 1'b0, 1'b0);
        run(1);
        check("at_0100", 16'h0100, 1'b0, 1'b0);
        run(4);
        check("borrow_0059", 16'h0059, 1'b0, 1'b0);

        // 00:02 to zero: done pulse for one cycle, then idle at zero
        cyc(1'b0, 1'b0, 1'b0, 4'd0);
        check("clear", 16'h0000, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 4'd2);
        check("load_0002", 16'h0002, 1'b0, 1'b0);
        run(3);
        check("pre_0001", 16'h0002, 1'b0, 1'b0);
        run(1);
        check("at_0001", 16'h0001, 1'b0, 1'b0);
        run(3);
        check("pre_zero", 16'h0001, 1'b0, 1'b0);
        run(1);
        check("reach_zero", 16'h0000, 1'b1, 1'b1);
        for (int i = 0; i < 20; i++) begin
            run(1);
            check($sformatf("hold_zero%0d", i), 16'h0000, 1'b1, 1'b0);
        end

        // 00:90 borrows digit-wise; pause restarts a full second
        cyc(1'b0, 1'b0, 1'b0, 4'd0);
        cyc(1'b0, 1'b1, 1'b1, 4'd9);
        cyc(1'b0, 1'b1, 1'b1, 4'd0);
        check("load_0090", 16'h0090, 1'b0, 1'b0);
        run(4);
        check("dec_0089", 16'h0089, 1'b0, 1'b0);
        run(2);
        cyc(1'b0, 1'b1, 1'b0, 4'd0);
        check("paused", 16'h0089, 1'b0, 1'b0);
        run(3);
        check("resume_pre", 16'h0089, 1'b0, 1'b0);
        run(1);
        check("resume_0088", 16'h0088, 1'b0, 1'b0);

        // Keypad and clear ignored while running; clear honoured once stopped
        cyc(1'b1, 1'b0, 1'b1, 4'd5);
        check("ignore_run", 16'h0088, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 4'd0);
        check("clear_stopped", 16'h0000, 1'b1, 1'b0);

        // Enable dropping on the tick cycle discards that tick
        cyc(1'b0, 1'b1, 1'b1, 4'd5);
        run(3);
        check("pre_drop", 16'h0005, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 4'd0);
        check("tick_dropped", 16'h0005, 1'b0, 1'b0);
        run(3);
        check("refill_pre", 16'h0005, 1'b0, 1'b0);
        run(1);
        check("refill_0004", 16'h0004, 1'b0, 1'b0);

        // Asynchronous reset mid-count at 00:37
        cyc(1'b0, 1'b0, 1'b0, 4'd0);
        cyc(1'b0, 1'b1, 1'b1, 4'd3);
        cyc(1'b0, 1'b1, 1'b1, 4'd7);
        check("load_0037", 16'h0037, 1'b0, 1'b0);
        run(2);
        #2;
        resetn = 1'b0;
        #1;
        check("async_reset", 16'h0000, 1'b1, 1'b0);
        @(negedge clk);
        enable = 1'b0;
        resetn = 1'b1;
        cyc(1'b0, 1'b1, 1'b1, 4'd3);
        cyc(1'b0, 1'b1, 1'b1, 4'd7);
        run(3);
        check("post_reset_pre", 16'h0037, 1'b0, 1'b0);
        run(1);
        check("post_reset_0036", 16'h0036, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
